// File: rtl/child_seq_pkg.sv
// Shared types and defaults for the child instance sequencer.
// CHILD_SEQ_TIMEOUT_EN only changes the RTL, not this package.
package child_seq_pkg;

  localparam int NUM_CHILD_DEF   = 5;
  localparam int TIMEOUT_CYC_DEF = 200;
  localparam int IDX_W_DEF       = $clog2(NUM_CHILD_DEF + 1);

  typedef logic [IDX_W_DEF-1:0] idx_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SCAN   = 3'd1,
    START  = 3'd2,
    WAIT   = 3'd3,
    FINISH = 3'd4
  } seq_state_e;

endpackage

// File: rtl/child_instance_sequencer_if.sv
// Run request/status and per-child start/done bundle between the sequencer and its surroundings.
// The master side is the sequencer; err_o/err_idx_o read 0 unless CHILD_SEQ_TIMEOUT_EN is defined.
interface child_instance_sequencer_if
  import child_seq_pkg::*;
#(
  parameter int NUM_CHILD = NUM_CHILD_DEF,
  parameter int IDX_W     = $clog2(NUM_CHILD + 1)
);

  logic                 go_i;
  logic [NUM_CHILD-1:0] enable_mask_i;
  logic                 busy_o;
  logic                 done_o;
  logic [NUM_CHILD-1:0] child_start_o;
  logic [NUM_CHILD-1:0] child_done_i;
  logic [IDX_W-1:0]     cur_idx_o;
  logic                 err_o;
  logic [IDX_W-1:0]     err_idx_o;

  modport master (
    input  go_i, enable_mask_i, child_done_i,
    output busy_o, done_o, child_start_o, cur_idx_o, err_o, err_idx_o
  );

  modport slave (
    output go_i, enable_mask_i, child_done_i,
    input  busy_o, done_o, child_start_o, cur_idx_o, err_o, err_idx_o
  );

endinterface

// File: rtl/child_seq_timer.sv
// Per-child WAIT timeout counter; only instantiated when CHILD_SEQ_TIMEOUT_EN is defined.
// expired_o fires on the TIMEOUT_CYC-th consecutive enabled cycle after a clear.
module child_seq_timer #(
  parameter int TIMEOUT_CYC = 200,
  parameter int TO_W        = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the number of WAIT cycles already completed.
  assign expired_o = en_i && (cnt_q == TO_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/child_instance_sequencer.sv
// Starts each enabled child in ascending index order and waits for its done before moving on.
// Define CHILD_SEQ_TIMEOUT_EN to add hang detection (err_o/err_idx_o) on children that never finish.
module child_instance_sequencer
  import child_seq_pkg::*;
#(
  parameter int NUM_CHILD   = NUM_CHILD_DEF,
  parameter int IDX_W       = $clog2(NUM_CHILD + 1),
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int TO_W        = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  child_instance_sequencer_if.master bus
);

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_SCAN   = SCAN;
  localparam logic [2:0] ST_START  = START;
  localparam logic [2:0] ST_WAIT   = WAIT;
  localparam logic [2:0] ST_FINISH = FINISH;

  if (NUM_CHILD < 2 || TIMEOUT_CYC >= (1 << TO_W)) begin : g_bad_cfg
    $error("child_instance_sequencer: unsupported NUM_CHILD/TIMEOUT_CYC/TO_W combination");
  end

  logic [2:0]           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NUM_CHILD-1:0] mask_q, mask_d;
  logic [NUM_CHILD-1:0] idx_onehot;
  logic                 sel_enabled;
  logic                 sel_done;
  logic                 at_end;

  // One-hot of the addressed child; all zero once idx has walked past the last child.
  assign idx_onehot  = NUM_CHILD'(1) << idx_q;
  assign sel_enabled = |(mask_q & idx_onehot);
  assign sel_done    = |(bus.child_done_i & idx_onehot);
  assign at_end      = (idx_q == IDX_W'(NUM_CHILD));

`ifdef CHILD_SEQ_TIMEOUT_EN
  logic             timeout;
  logic             err_q, err_d;
  logic [IDX_W-1:0] err_idx_q, err_idx_d;

  child_seq_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (state_q == ST_START),
    .en_i      (state_q == ST_WAIT),
    .expired_o (timeout)
  );
`endif

  // NOTE: every always_comb target gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
`ifdef CHILD_SEQ_TIMEOUT_EN
    err_d     = err_q;
    err_idx_d = err_idx_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.go_i) begin
          mask_d  = bus.enable_mask_i;
          idx_d   = '0;
          state_d = ST_SCAN;
`ifdef CHILD_SEQ_TIMEOUT_EN
          err_d     = 1'b0;
          err_idx_d = '0;
`endif
        end
      end
      ST_SCAN: begin
        if (at_end) begin
          state_d = ST_FINISH;
        end else if (sel_enabled) begin
          state_d = ST_START;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        // A done in the same cycle as the timeout takes priority.
        if (sel_done) begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_SCAN;
        end
`ifdef CHILD_SEQ_TIMEOUT_EN
        else if (timeout) begin
          err_d = 1'b1;
          if (!err_q) begin
            err_idx_d = idx_q;
          end
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_SCAN;
        end
`endif
      end
      ST_FINISH: begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state is written only with non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
    end
  end

`ifdef CHILD_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else begin
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
    end
  end

  assign bus.err_o     = err_q;
  assign bus.err_idx_o = err_idx_q;
`else
  assign bus.err_o     = 1'b0;
  assign bus.err_idx_o = '0;
`endif

  assign bus.busy_o        = (state_q != ST_IDLE);
  assign bus.done_o        = (state_q == ST_FINISH);
  assign bus.child_start_o = (state_q == ST_START) ? idx_onehot : '0;
  assign bus.cur_idx_o     = idx_q;

endmodule

// File: tb/tb_child_instance_sequencer.sv
// Directed and randomized run schedules for child_instance_sequencer, checked cycle by cycle
// against a schedule model derived from the sequencing rules (define CHILD_SEQ_TIMEOUT_EN for the hang cases).
module tb_child_instance_sequencer;
  import child_seq_pkg::*;

  localparam int N     = NUM_CHILD_DEF;
  localparam int IW    = $clog2(N + 1);
  localparam int TCYC  = TIMEOUT_CYC_DEF;
  localparam int NEVER = 0;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  child_instance_sequencer_if #(.NUM_CHILD(N), .IDX_W(IW)) bus ();

  child_instance_sequencer #(
    .NUM_CHILD   (N),
    .IDX_W       (IW),
    .TIMEOUT_CYC (TCYC),
    .TO_W        (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Run schedule, in cycles counted from the cycle in which go is presented (cycle 0).
  int   lat_v   [N];
  int   scan_c  [N+1];
  int   start_c [N];
  int   wend_c  [N];
  int   ddone_c [N];
  int   fin_c;
  int   err_c;
  int   err_i;
  bit   prev_err;
  idx_t prev_err_idx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic busy, input logic done,
                               input logic [N-1:0] start, input int idx,
                               input logic err, input int err_idx);
    check({tag, " busy"},    32'(bus.busy_o),        32'(busy));
    check({tag, " done"},    32'(bus.done_o),        32'(done));
    check({tag, " start"},   32'(bus.child_start_o), 32'(start));
    check({tag, " idx"},     32'(bus.cur_idx_o),     32'(idx));
    check({tag, " err"},     32'(bus.err_o),         32'(err));
    check({tag, " err_idx"}, 32'(bus.err_idx_o),     32'(err_idx));
  endtask

  // Each child: skipped -> one SCAN cycle; enabled -> SCAN, START, WAIT until done (or timeout).
  task automatic plan(input logic [N-1:0] mask);
    int t;
    t     = 1;
    err_c = -1;
    err_i = 0;
    for (int i = 0; i < N; i++) begin
      scan_c[i]  = t;
      start_c[i] = -1;
      wend_c[i]  = -1;
      ddone_c[i] = -1;
      if (mask[i]) begin
        start_c[i] = t + 1;
`ifdef CHILD_SEQ_TIMEOUT_EN
        if (lat_v[i] == NEVER || lat_v[i] > TCYC) begin
          wend_c[i] = start_c[i] + TCYC;
          if (err_c < 0) begin
            err_c = wend_c[i] + 1;
            err_i = i;
          end
        end else begin
          wend_c[i]  = start_c[i] + lat_v[i];
          ddone_c[i] = wend_c[i];
        end
`else
        wend_c[i]  = start_c[i] + lat_v[i];
        ddone_c[i] = wend_c[i];
`endif
        t = wend_c[i] + 1;
      end else begin
        t++;
      end
    end
    scan_c[N] = t;
    fin_c     = t + 1;
  endtask

  function automatic int exp_idx(input int c);
    int r;
    r = 0;
    if (c >= 1 && c <= fin_c) begin
      for (int i = 0; i <= N; i++) begin
        if (scan_c[i] <= c) r = i;
      end
    end
    return r;
  endfunction

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      bus.go_i          = 1'b0;
      bus.enable_mask_i = N'($urandom);
      bus.child_done_i  = N'($urandom);
      @(negedge clk);
      check_outputs("idle", 1'b0, 1'b0, '0, 0, prev_err, int'(prev_err_idx));
    end
  endtask

  task automatic run_case(input string name, input logic [N-1:0] mask, input bit hold,
                          input bit noise, input bit stray3, input int abort_child);
    logic [N-1:0] cd;
    logic [N-1:0] st;
    int           abort_c;
    bit           e;
    plan(mask);
    abort_c = (abort_child >= 0) ? start_c[abort_child] + 2 : -1;
    for (int c = 0; c <= fin_c; c++) begin
      @(posedge clk); #1;
      bus.go_i          = (c == 0) || hold;
      bus.enable_mask_i = (c == 0) ? mask : N'($urandom);
      cd = '0;
      for (int j = 0; j < N; j++) begin
        if (wend_c[j] >= 0 && c > start_c[j] && c <= wend_c[j]) cd[j] = (c == ddone_c[j]);
        else if (noise) cd[j] = 1'($urandom);
      end
      if (stray3 && exp_idx(c) == 1) cd[3] = 1'b1;
      bus.child_done_i = cd;
      st = '0;
      for (int j = 0; j < N; j++) begin
        if (start_c[j] == c) st[j] = 1'b1;
      end
      @(negedge clk);
      if (c == 0) begin
        check_outputs($sformatf("%s c%0d", name, c), 1'b0, 1'b0, '0, 0, prev_err, int'(prev_err_idx));
      end else begin
        e = (err_c >= 0) && (c >= err_c);
        check_outputs($sformatf("%s c%0d", name, c), 1'b1, c == fin_c, st, exp_idx(c),
                      e, e ? err_i : 0);
      end
      if (c == abort_c) begin
        #2 rst_n = 1'b0;
        #1 check_outputs($sformatf("%s async_rst", name), 1'b0, 1'b0, '0, 0, 1'b0, 0);
        bus.go_i         = 1'b0;
        bus.child_done_i = '0;
        prev_err         = 1'b0;
        prev_err_idx     = '0;
        return;
      end
    end
    prev_err     = (err_c >= 0);
    prev_err_idx = (err_c >= 0) ? idx_t'(err_i) : '0;
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.go_i          = 1'b0;
    bus.enable_mask_i = '0;
    bus.child_done_i  = '0;
    prev_err          = 1'b0;
    prev_err_idx      = '0;
    repeat (3) @(negedge clk);
    check_outputs("reset", 1'b0, 1'b0, '0, 0, 1'b0, 0);
    rst_n = 1'b1;
    idle(2);

    // All children enabled, each answering 3 cycles after its start.
    for (int i = 0; i < N; i++) lat_v[i] = 3;
    run_case("all_on", 5'b11111, 1'b0, 1'b0, 1'b0, -1);
    idle(2);

    // Sparse mask with stray done noise on the other children.
    for (int i = 0; i < N; i++) lat_v[i] = $urandom_range(1, 4);
    run_case("sparse", 5'b10100, 1'b0, 1'b1, 1'b0, -1);
    idle(1);

    // Empty mask: done lands NUM_CHILD+2 cycles after go.
    run_case("empty", 5'b00000, 1'b0, 1'b1, 1'b0, -1);

    // go held high through the run plus a stray done on child 3 while idx=1,
    // then the still-high go launches the next run back to back.
    for (int i = 0; i < N; i++) lat_v[i] = $urandom_range(1, 4);
    run_case("hold", 5'b11111, 1'b1, 1'b1, 1'b1, -1);
    for (int i = 0; i < N; i++) lat_v[i] = $urandom_range(1, 4);
    run_case("rerun", 5'b01101, 1'b0, 1'b1, 1'b0, -1);
    idle(1);

    // Reset while waiting on child 2, then a clean restart from child 0.
    for (int i = 0; i < N; i++) lat_v[i] = 2;
    lat_v[2] = 10;
    run_case("abort", 5'b11111, 1'b0, 1'b0, 1'b0, 2);
    repeat (2) begin
      @(negedge clk);
      check_outputs("in_reset", 1'b0, 1'b0, '0, 0, 1'b0, 0);
    end
    rst_n = 1'b1;
    idle(3);
    for (int i = 0; i < N; i++) lat_v[i] = 2;
    run_case("restart", 5'b11111, 1'b0, 1'b0, 1'b0, -1);

    // Random masks and latencies.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) lat_v[i] = $urandom_range(1, 5);
      run_case($sformatf("rand%0d", r), N'($urandom), 1'b0, 1'b1, 1'b0, -1);
      idle($urandom_range(0, 2));
    end

`ifdef CHILD_SEQ_TIMEOUT_EN
    // Child 1 hangs; child 2 still runs and the run completes with an error.
    for (int i = 0; i < N; i++) lat_v[i] = 2;
    lat_v[1] = NEVER;
    run_case("hang1", 5'b00111, 1'b0, 1'b1, 1'b0, -1);
    idle(1);
    // Next go clears the error; a done in the timeout cycle wins.
    lat_v[0] = TCYC;
    run_case("done_wins", 5'b00001, 1'b0, 1'b0, 1'b0, -1);
    // Two hung children: err_idx keeps the first.
    for (int i = 0; i < N; i++) lat_v[i] = 1;
    lat_v[1] = NEVER;
    lat_v[2] = NEVER;
    run_case("hang12", 5'b00110, 1'b0, 1'b0, 1'b0, -1);
    idle(2);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/child_instance_sequencer.md
Name: child_instance_sequencer

Overview:
- Sequences start/done handshakes across the NUM_CHILD child instances of a root module (inst_0..inst_4 by default), one at a time in ascending index order.
- Sits beside the root-level instance list. Gives a single go/done interface to the level above and skips children masked off for a run.

Parameters:
- NUM_CHILD, 5, number of child instances sequenced (≥2)
- IDX_W, $clog2(NUM_CHILD+1), width of the index counter and index outputs
- TIMEOUT_CYC, 200, WAIT cycles before a child is declared hung (used only with the optional feature)
- TO_W, 8, timeout counter width; TIMEOUT_CYC must be < 2**TO_W

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- go_i  input  1  run request; sampled only in IDLE
- enable_mask_i  input  NUM_CHILD  per-child enable; latched when go is accepted
- busy_o  output  1  high in every state except IDLE
- done_o  output  1  one-cycle pulse at run end
- child_start_o  output  NUM_CHILD  one-hot, one-cycle start pulse
- child_done_i  input  NUM_CHILD  per-child completion, level or pulse
- cur_idx_o  output  IDX_W  index currently addressed; 0 in IDLE
- err_o  output  1  sticky timeout flag for the current/last run
- err_idx_o  output  IDX_W  index of the first child that timed out

Behaviour:
- Reset (async assert, sync deassert by the environment):
  - state=IDLE; all outputs 0; latched mask=0; idx=0.
  - Reset mid-run abandons the run immediately; no done_o is issued.
- Registered FSM with states IDLE, SCAN, START, WAIT, FINISH. All outputs are registered or decoded from state/idx.
- IDLE:
  - go_i=1 -> latch enable_mask_i, clear err_o/err_idx_o, idx=0, go to SCAN.
  - go_i in any other state is ignored; it is not queued.
- SCAN:
  - idx==NUM_CHILD -> FINISH.
  - mask[idx]=1 -> START.
  - mask[idx]=0 -> idx+1, stay in SCAN. Each skipped child costs one cycle.
- START: child_start_o[idx]=1 for exactly this cycle -> WAIT.
- WAIT:
  - child_done_i[idx]=1 -> idx+1, SCAN.
  - child_done_i is sampled only in WAIT and only for bit idx. Other bits, and done asserted during START, are ignored.
- FINISH: done_o=1 for one cycle -> IDLE. cur_idx_o returns to 0 in IDLE.
- Latency: go edge -> first child_start_o = 2 cycles if child 0 is enabled (SCAN, START).
  - Per enabled child: START + WAIT (≥1) + SCAN = ≥3 cycles.
  - All-zero mask: go -> SCAN×(NUM_CHILD+1) -> FINISH; done_o appears NUM_CHILD+2 cycles after go.
- Index arithmetic is unsigned IDX_W. idx never exceeds NUM_CHILD, so there is no wrap.

Optional Feature:
- Macro: CHILD_SEQ_TIMEOUT_EN
- Defined:
  - Timeout counter clears on entry to WAIT and increments each WAIT cycle.
  - Count reaching TIMEOUT_CYC without done -> set err_o. If err_o was previously 0, latch err_idx_o=idx.
  - Then idx+1 and SCAN; the run continues.
  - A done arriving in the same cycle as the timeout wins; no error.
- Undefined: WAIT has no exit except done; err_o and err_idx_o are tied 0; no counter logic.

Decomposition:
- Package child_seq_pkg holds:
  - seq_state_e enum (IDLE, SCAN, START, WAIT, FINISH)
  - NUM_CHILD_DEF=5, TIMEOUT_CYC_DEF=200
  - idx_t typedef
- One sub-module: child_seq_timer, holding the timeout counter with clear/enable/expired. It is instantiated only under CHILD_SEQ_TIMEOUT_EN.

Test Plan:
- Mask 5'b11111, each child returns done 3 cycles after its start -> starts on idx 0..4 in order, one-hot, 1 cycle each; done_o once; busy_o low afterward.
- Mask 5'b10100 -> starts only on idx 2 and 4; skipped children cost 1 cycle each; cur_idx_o steps 0,1,2,3,4,5,0.
- Mask 5'b00000 -> no starts; done_o exactly 7 cycles after go.
- go_i held high for the whole run, plus child_done_i[3] asserted while idx=1 -> the extra go is ignored and the stray done is ignored; after done_o, the still-high go starts a new run.
- rst_n low during WAIT on idx 2 -> outputs 0 asynchronously; no done_o; the next go restarts at idx 0.
- With CHILD_SEQ_TIMEOUT_EN and TIMEOUT_CYC=200, child 1 never returns done -> err_o=1 and err_idx_o=1; child 2 still starts; done_o is issued; the next go clears err_o.
